bbox_pixel_scanner: RTL

//  Consumer end of the bounding-box handshake. Accepts one clamped box
//  {min_x,max_x,min_y,max_y} per triangle from the bbox calculator via calc_done/read_done.

---
 rtl/raster_pkg.sv | 18 +
 rtl/raster_xy_counter.sv | 73 +++++++
 rtl/bbox_pixel_scanner.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/raster_pkg.sv
// Shared rasteriser definitions: scanner FSM states and bounding-box index names.
package raster_pkg;

  typedef enum logic [1:0] {
    SCAN_IDLE,
    SCAN_ACK,
    SCAN_RUN,
    SCAN_DONE
  } scan_state_t;

  // Index names for the four entries of a bounding box.
  localparam int unsigned BBOX_MIN_X = 0;
  localparam int unsigned BBOX_MAX_X = 1;
  localparam int unsigned BBOX_MIN_Y = 2;
  localparam int unsigned BBOX_MAX_Y = 3;
  localparam int unsigned BBOX_N     = 4;

endpackage

// File: rtl/raster_xy_counter.sv
// Raster-order x/y walker over a captured bounding box.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   load          restart at (min_x, min_y)
//   advance       step one pixel: x inner, y outer
//   box[4]        {min_x, max_x, min_y, max_y}, held stable while walking
//   x, y          current pixel (registered)
//   first, last   current pixel is the first / last of the box (registered)
module raster_xy_counter
  import raster_pkg::*;
#(
  parameter int unsigned COORD_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               advance,
  input  logic [COORD_W-1:0] box [BBOX_N],
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               first,
  output logic               last
);

  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               first_q, first_d;
  logic               last_q, last_d;

  // Next position; end-of-row/box tests use equality so max=all-ones never wraps.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    first_d = first_q;
    last_d  = last_q;
    if (load) begin
      x_d = box[BBOX_MIN_X];
      y_d = box[BBOX_MIN_Y];
    end else if (advance) begin
      if (x_q != box[BBOX_MAX_X]) begin
        x_d = x_q + COORD_W'(1);
      end else if (y_q != box[BBOX_MAX_Y]) begin
        x_d = box[BBOX_MIN_X];
        y_d = y_q + COORD_W'(1);
      end
    end
    // Flags only track the position while it is being driven, so they idle at 0 after reset.
    if (load || advance) begin
      first_d = (x_d == box[BBOX_MIN_X]) && (y_d == box[BBOX_MIN_Y]);
      last_d  = (x_d == box[BBOX_MAX_X]) && (y_d == box[BBOX_MAX_Y]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= '0;
      y_q     <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign first = first_q;
  assign last  = last_q;

endmodule

// File: rtl/bbox_pixel_scanner.sv
// Bounding-box consumer: captures one box per triangle and streams every
// pixel inside it in raster order over a valid/ready interface.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   bbox_calc_done, bbox_in[4]   box offered by the bbox calculator
//   bbox_read_done               pulse: box captured, producer may release it
//   pix_valid/pix_ready          pixel beat handshake
//   pix_x, pix_y                 pixel coordinate of the beat
//   pix_first, pix_last          beat is first / last pixel of the box
//   tri_done                     pulse: box finished (also for an empty box)
//   busy                         scanner not idle
//   pix_count                    beats accepted for current/most recent box (saturating)
module bbox_pixel_scanner
  import raster_pkg::*;
#(
  parameter int unsigned COORD_W   = 32,
  parameter int unsigned PIX_CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bbox_calc_done,
  input  logic [COORD_W-1:0]   bbox_in [BBOX_N],
  output logic                 bbox_read_done,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic [COORD_W-1:0]   pix_x,
  output logic [COORD_W-1:0]   pix_y,
  output logic                 pix_first,
  output logic                 pix_last,
  output logic                 tri_done,
  output logic                 busy,
  output logic [PIX_CNT_W-1:0] pix_count
);

  scan_state_t          state_q, state_d;
  logic                 pending_q, pending_d;
  logic [COORD_W-1:0]   box_q [BBOX_N];
  logic [COORD_W-1:0]   box_d [BBOX_N];
  logic [PIX_CNT_W-1:0] count_q, count_d;
  logic                 read_done_q, read_done_d;
  logic                 valid_q, valid_d;
  logic                 tri_done_q, tri_done_d;
  logic                 busy_q, busy_d;
  logic                 load_c;
  logic                 advance_c;

  // Next-state, pending flag and registered-output decode.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    box_d     = box_q;
    count_d   = count_q;
    load_c    = 1'b0;
    advance_c = 1'b0;

    case (state_q)
      SCAN_IDLE: begin
        if (bbox_calc_done || pending_q) begin
          box_d     = bbox_in;
          pending_d = 1'b0;
          count_d   = '0;
          state_d   = SCAN_ACK;
        end
      end
      SCAN_ACK: begin
        load_c = 1'b1;
        if ((box_q[BBOX_MIN_X] <= box_q[BBOX_MAX_X]) &&
            (box_q[BBOX_MIN_Y] <= box_q[BBOX_MAX_Y])) begin
          state_d = SCAN_RUN;
        end else begin
          state_d = SCAN_DONE;
        end
      end
      SCAN_RUN: begin
        if (valid_q && pix_ready) begin
          advance_c = 1'b1;
          if (count_q != {PIX_CNT_W{1'b1}}) begin
            count_d = count_q + PIX_CNT_W'(1);
          end
          if (pix_last) begin
            state_d = SCAN_DONE;
          end
        end
      end
      SCAN_DONE: begin
        state_d = SCAN_IDLE;
      end
      default: begin
        state_d = SCAN_IDLE;
      end
    endcase

    // A box offered while we are busy is remembered; the producer holds it until read_done.
    if ((state_q != SCAN_IDLE) && bbox_calc_done) begin
      pending_d = 1'b1;
    end

    read_done_d = (state_d == SCAN_ACK);
    valid_d     = (state_d == SCAN_RUN);
    tri_done_d  = (state_d == SCAN_DONE);
    busy_d      = (state_d != SCAN_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCAN_IDLE;
      pending_q   <= 1'b0;
      count_q     <= '0;
      read_done_q <= 1'b0;
      valid_q     <= 1'b0;
      tri_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < BBOX_N; i++) begin
        box_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      count_q     <= count_d;
      read_done_q <= read_done_d;
      valid_q     <= valid_d;
      tri_done_q  <= tri_done_d;
      busy_q      <= busy_d;
      for (int i = 0; i < BBOX_N; i++) begin
        box_q[i] <= box_d[i];
      end
    end
  end

  raster_xy_counter #(
    .COORD_W (COORD_W)
  ) u_xy (
    .clk     (clk),
    .rst     (rst),
    .load    (load_c),
    .advance (advance_c),
    .box     (box_q),
    .x       (pix_x),
    .y       (pix_y),
    .first   (pix_first),
    .last    (pix_last)
  );

  assign bbox_read_done = read_done_q;
  assign pix_valid      = valid_q;
  assign tri_done       = tri_done_q;
  assign busy           = busy_q;
  assign pix_count      = count_q;

endmodule
